// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the Ethernet RX destination-address filter.
package eth_frame_pkg;

    typedef enum logic [1:0] {
        HDR,
        REPLAY,
        PASS,
        DROP
    } state_t;

    localparam int          ETH_ADDR_BYTES = 6;
    localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam logic [2:0]  HDR_LAST_IDX   = 3'(ETH_ADDR_BYTES - 1);

endpackage

// File: rtl/eth_addr_match.sv
// Combinational accept decision for a buffered destination MAC address.
module eth_addr_match
    import eth_frame_pkg::*;
(
    input  logic [47:0] addr,
    input  logic [47:0] cfg_mac_addr,
    input  logic        cfg_enable,
    input  logic        cfg_promisc,
    input  logic        cfg_bcast_en,
    input  logic        hdr_bad,
    output logic        match
);

    logic is_station;
    logic is_bcast;

    assign is_station = (addr == cfg_mac_addr);
    assign is_bcast   = (addr == ETH_BCAST_ADDR);
    assign match      = cfg_enable & ~hdr_bad &
                        (cfg_promisc | is_station | (cfg_bcast_en & is_bcast));

endmodule

// File: rtl/eth_rx_addr_filter.sv
// Destination-MAC filter between MAC RX AXI-Stream and the uDMA frame bridge.
// Optional drop statistics counter enabled by ETH_RX_FILTER_STATS_EN.
//
//   state  | meaning
//   HDR    | collecting the 6 destination-address bytes
//   REPLAY | emitting the buffered header downstream, input stalled
//   PASS   | combinational pass-through until the frame's tlast
//   DROP   | consuming the rest of a rejected frame
module eth_rx_addr_filter
    import eth_frame_pkg::*;
`ifdef ETH_RX_FILTER_STATS_EN
#(
    parameter int CNT_WIDTH = 16
)
`endif
(
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [47:0]          cfg_mac_addr_i,
    input  logic                 cfg_enable_i,
    input  logic                 cfg_promisc_i,
    input  logic                 cfg_bcast_en_i,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic                 m_axis_tready,
    output logic                 frame_accepted_o,
    output logic                 frame_dropped_o
`ifdef ETH_RX_FILTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] drop_count_o
`endif
);

    state_t      state_q, state_d;
    logic [2:0]  idx_q;
    logic [2:0]  ridx_q;
    logic [7:0]  hdr_buf_q [ETH_ADDR_BYTES];
    logic        hdr_bad_q;
    logic        hdr_bad_now;
    logic [47:0] addr;
    logic        match;

    // The last header byte is still on the bus when the decision is made.
    assign hdr_bad_now = hdr_bad_q | s_axis_tuser;
    assign addr        = {hdr_buf_q[0], hdr_buf_q[1], hdr_buf_q[2],
                          hdr_buf_q[3], hdr_buf_q[4], s_axis_tdata};

    eth_addr_match u_match (
        .addr         (addr),
        .cfg_mac_addr (cfg_mac_addr_i),
        .cfg_enable   (cfg_enable_i),
        .cfg_promisc  (cfg_promisc_i),
        .cfg_bcast_en (cfg_bcast_en_i),
        .hdr_bad      (hdr_bad_now),
        .match        (match)
    );

    always_comb begin
        state_d          = state_q;
        s_axis_tready    = 1'b0;
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = 8'h00;
        m_axis_tlast     = 1'b0;
        m_axis_tuser     = 1'b0;
        frame_accepted_o = 1'b0;
        frame_dropped_o  = 1'b0;
        case (state_q)
            HDR: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        frame_dropped_o = 1'b1;
                    end else if (idx_q == HDR_LAST_IDX) begin
                        state_d = match ? REPLAY : DROP;
                    end
                end
            end
            REPLAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_buf_q[ridx_q];
                if (m_axis_tready && (ridx_q == HDR_LAST_IDX)) begin
                    state_d = PASS;
                end
            end
            PASS: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    frame_accepted_o = 1'b1;
                    state_d          = HDR;
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    frame_dropped_o = 1'b1;
                    state_d         = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= HDR;
            idx_q     <= 3'd0;
            ridx_q    <= 3'd0;
            hdr_bad_q <= 1'b0;
            for (int i = 0; i < ETH_ADDR_BYTES; i++) begin
                hdr_buf_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                HDR: begin
                    if (s_axis_tvalid) begin
                        hdr_buf_q[idx_q] <= s_axis_tdata;
                        // Runt end or full header both restart collection.
                        if (s_axis_tlast || (idx_q == HDR_LAST_IDX)) begin
                            idx_q     <= 3'd0;
                            hdr_bad_q <= 1'b0;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            hdr_bad_q <= hdr_bad_now;
                        end
                    end
                end
                REPLAY: begin
                    if (m_axis_tready) begin
                        ridx_q <= (ridx_q == HDR_LAST_IDX) ? 3'd0 : ridx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drop_cnt_q <= '0;
        end else if (frame_dropped_o && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Randomized self-checking bench for eth_rx_addr_filter against a frame-level model.
module tb_eth_rx_addr_filter;

    localparam int          TB_CNT_W = 2;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] STA_MAC  = 48'h02_00_00_00_00_01;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [47:0] cfg_mac_addr_i;
    logic        cfg_enable_i, cfg_promisc_i, cfg_bcast_en_i;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic        frame_accepted_o, frame_dropped_o;
`ifdef ETH_RX_FILTER_STATS_EN
    logic [TB_CNT_W-1:0] drop_count_o;
`endif

    always #5 clk_i = ~clk_i;

`ifdef ETH_RX_FILTER_STATS_EN
    eth_rx_addr_filter #(.CNT_WIDTH(TB_CNT_W)) dut (
`else
    eth_rx_addr_filter dut (
`endif
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .cfg_mac_addr_i   (cfg_mac_addr_i),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_promisc_i    (cfg_promisc_i),
        .cfg_bcast_en_i   (cfg_bcast_en_i),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tready    (m_axis_tready),
        .frame_accepted_o (frame_accepted_o),
        .frame_dropped_o  (frame_dropped_o)
`ifdef ETH_RX_FILTER_STATS_EN
        ,
        .drop_count_o     (drop_count_o)
`endif
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    int    exp_acc, exp_drop, seen_acc, seen_drop, total_drop;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: a frame is forwarded whole or not at all.
    task automatic add_frame(input logic [47:0] dst, input int len, input int err_pos);
        beat_t b;
        bit    bad = 1'b0;
        bit    acc;
        beat_t fr[$];
        for (int i = 0; i < len; i++) begin
            b.data = (i < 6) ? dst[47 - 8*i -: 8] : 8'($urandom);
            b.last = (i == len - 1);
            b.user = (i == err_pos);
            if (i < 6 && i == err_pos) bad = 1'b1;
            fr.push_back(b);
            in_q.push_back(b);
        end
        acc = cfg_enable_i && (len > 6) && !bad &&
              (cfg_promisc_i || dst == cfg_mac_addr_i || (cfg_bcast_en_i && dst == BCAST));
        if (acc) begin
            foreach (fr[i]) exp_q.push_back(fr[i]);
            exp_acc++;
        end else begin
            exp_drop++;
            total_drop++;
        end
    endtask

    task automatic run_stream(input int max_cycles, input bit rdy_rand, input bit vld_rand,
                              input bit expect_done);
        int    cyc = 0, idle = 0;
        bit    have = 1'b0, stall_prev = 1'b0;
        beat_t cur = '0, prev = '0, e;
        seen_acc  = 0;
        seen_drop = 0;
        while (cyc < max_cycles && idle < 4) begin
            @(posedge clk_i);
            #1;
            if (!have && in_q.size() > 0 && (!vld_rand || $urandom_range(0, 9) < 8)) begin
                cur  = in_q.pop_front();
                have = 1'b1;
            end
            s_axis_tvalid = have;
            s_axis_tdata  = have ? cur.data : 8'h00;
            s_axis_tlast  = have ? cur.last : 1'b0;
            s_axis_tuser  = have ? cur.user : 1'b0;
            m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            if (stall_prev) begin
                check_eq("stall_valid", m_axis_tvalid, 1'b1);
                check_eq("stall_data", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev);
            end
            stall_prev = m_axis_tvalid & ~m_axis_tready;
            prev       = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, e);
                end
            end
            if (s_axis_tvalid && s_axis_tready) have = 1'b0;
            if (frame_accepted_o || frame_dropped_o)
                check_eq("pulse_excl", frame_accepted_o & frame_dropped_o, 1'b0);
            if (frame_accepted_o) seen_acc++;
            if (frame_dropped_o) seen_drop++;
            if (!have && in_q.size() == 0 && exp_q.size() == 0) idle++;
            cyc++;
        end
        if (expect_done) begin
            if (idle < 4) check_eq("timeout", 1'b1, 1'b0);
            check_eq("acc_pulses", seen_acc, exp_acc);
            check_eq("drop_pulses", seen_drop, exp_drop);
`ifdef ETH_RX_FILTER_STATS_EN
            check_eq("drop_count", drop_count_o, (total_drop > 3) ? 3 : total_drop);
`endif
        end
        exp_acc  = 0;
        exp_drop = 0;
    endtask

    task automatic set_cfg(input logic [47:0] mac, input bit en, input bit prom, input bit bc);
        cfg_mac_addr_i = mac;
        cfg_enable_i   = en;
        cfg_promisc_i  = prom;
        cfg_bcast_en_i = bc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_tready"}, s_axis_tready, 1'b1);
        check_eq({tag, "_m_out"}, {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 11'd0);
        check_eq({tag, "_pulses"}, {frame_accepted_o, frame_dropped_o}, 2'b00);
`ifdef ETH_RX_FILTER_STATS_EN
        check_eq({tag, "_drop_count"}, drop_count_o, 0);
`endif
    endtask

    initial begin
        logic [47:0] dst;
        int          len, err, kind;
        rstn_i        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        exp_acc = 0; exp_drop = 0; total_drop = 0;
        set_cfg(STA_MAC, 1'b1, 1'b0, 1'b0);
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;

        add_frame(STA_MAC, 64, -1);
        run_stream(400, 1'b0, 1'b0, 1'b1);

        add_frame(48'h02_00_00_00_00_02, 64, -1);
        run_stream(400, 1'b0, 1'b0, 1'b1);

        set_cfg(STA_MAC, 1'b1, 1'b0, 1'b1);
        add_frame(BCAST, 20, -1);
        run_stream(200, 1'b0, 1'b0, 1'b1);
        set_cfg(STA_MAC, 1'b1, 1'b0, 1'b0);
        add_frame(BCAST, 20, -1);
        run_stream(200, 1'b0, 1'b0, 1'b1);
        set_cfg(STA_MAC, 1'b1, 1'b1, 1'b0);
        add_frame(BCAST, 20, -1);
        run_stream(200, 1'b0, 1'b0, 1'b1);

        set_cfg(STA_MAC, 1'b1, 1'b0, 1'b0);
        add_frame(STA_MAC, 4, -1);
        add_frame(STA_MAC, 6, -1);
        add_frame(STA_MAC, 30, -1);
        run_stream(300, 1'b0, 1'b0, 1'b1);

        add_frame(STA_MAC, 100, -1);
        run_stream(1500, 1'b1, 1'b0, 1'b1);

        add_frame(STA_MAC, 40, 2);
        run_stream(300, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) add_frame(48'h0A_0B_0C_0D_0E_0F, 8 + i, -1);
        run_stream(400, 1'b0, 1'b0, 1'b1);

        for (int s = 0; s < 10; s++) begin
            set_cfg({16'($urandom), $urandom}, ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            for (int f = 0; f < 12; f++) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0:       dst = cfg_mac_addr_i;
                    1:       dst = cfg_mac_addr_i ^ (48'd1 << $urandom_range(0, 47));
                    2:       dst = BCAST;
                    default: dst = {16'($urandom), $urandom};
                endcase
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 80);
                err = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
                add_frame(dst, len, err);
            end
            run_stream(6000, 1'b1, 1'b1, 1'b1);
        end

        set_cfg(STA_MAC, 1'b1, 1'b0, 1'b0);
        add_frame(STA_MAC, 60, -1);
        run_stream(15, 1'b0, 1'b0, 1'b0);
        check_eq("mid_pass_valid", m_axis_tvalid, 1'b1);
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        s_axis_tvalid = 1'b0;
        in_q.delete();
        exp_q.delete();
        total_drop = 0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        add_frame(STA_MAC, 12, -1);
        run_stream(200, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
